fp16_mult: RTL and testbench
============================

FP16_MULT -- requirements
Module: fp16_mult

Interface
REQ-001 Parameter LATENCY, default 8, legal range 4..16: number of enabled clock edges from input capture to output update.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clk_en  input  1  pipeline advance enable.
REQ-005 dataa  input  16  IEEE-754 binary16 operand A.
REQ-006 datab  input  16  IEEE-754 binary16 operand B.
REQ-007 result  output  16  binary16 product, registered.
REQ-008 overflow  output  1  finite operands produced a result too large to represent; result is ±infinity.
REQ-009 underflow  output  1  nonzero exact product became zero or subnormal.
REQ-010 zero  output  1  result is ±0.
REQ-011 nan  output  1  result is NaN.

Function
REQ-012 Fully pipelined: a new operand pair is accepted on every rising edge with clk_en=1.
REQ-013 Operands captured on an enabled edge appear on result and flags exactly LATENCY enabled edges later; all flags stay aligned with their result.
REQ-014 clk_en=0 freezes every pipeline register and holds all outputs.
REQ-015 Sign of result = sign(dataa) XOR sign(datab), including zeros and infinities.
REQ-016 Normal path: 11x11-bit significand product (implicit 1s); exponent = ea+eb-15; normalize by at most 1 bit; round to nearest, ties to even; rounding carry renormalizes.
REQ-017 Biased exponent >= 31 after rounding, finite operands -> ±infinity (0x7C00/0xFC00), overflow=1.
REQ-018 Any NaN operand, or infinity times zero -> canonical NaN 0x7E00, nan=1, other flags 0.
REQ-019 Infinity times nonzero finite or infinity -> signed infinity, overflow=0.
REQ-020 Either operand zero, other finite -> signed zero, zero=1, underflow=0.
REQ-021 At most one of overflow, nan, zero is 1, except underflow and zero may both be 1.

Reset
REQ-022 reset=1 on a rising edge clears every pipeline stage; result=0x0000 and all flags 0 after that edge.
REQ-023 reset has priority over clk_en; in-flight operations are discarded and no stale result appears afterwards.
REQ-024 After reset, outputs stay 0x0000 with flags 0 until the first post-reset capture emerges LATENCY enabled edges later.

Configuration
REQ-025 Macro FP16_MULT_SUBNORMAL_EN selects subnormal support.
REQ-026 Without the macro: subnormal inputs are treated as signed zero; any result below 2^-14 is flushed to signed zero with zero=1; underflow=1 if the exact product was nonzero.
REQ-027 With the macro: subnormal inputs use the implicit-0 significand; tiny results are denormalized with correct round-to-nearest-even (gradual underflow); underflow=1 whenever the rounded result is subnormal or zero from a nonzero exact product; zero=1 only if the rounded result is zero.

Verification
REQ-028 0x3C00 x 0x4000, clk_en=1 -> 0x4000 after 8 edges, all flags 0.
REQ-029 0x7BFF x 0x4000 -> 0x7C00, overflow=1; 0x7C00 x 0x0000 -> 0x7E00, nan=1.
REQ-030 0x0400 x 0x0400 -> 0x0000, underflow=1, zero=1, in both configurations; 0x8000 x 0x3C00 -> 0x8000, zero=1, underflow=0.
REQ-031 Back-to-back issue of 0x3C00x0x3C00, 0x4000x0x4000, 0xC000x0x3800 -> 0x3C00, 0x4400, 0xBC00 on consecutive cycles, 8 edges after each issue.
REQ-032 Drop clk_en for 5 cycles mid-stream -> outputs hold; results resume in order once clk_en returns, each after 8 enabled edges.
REQ-033 Assert reset with 3 operations in flight -> next cycle result=0x0000, flags 0; none of the 3 results ever appears.

Source files
------------

// File: rtl/fp16_mult.sv
// fp16_mult: IEEE-754 binary16 multiplier with a LATENCY-deep registered output pipeline.
// Define FP16_MULT_SUBNORMAL_EN for gradual underflow; by default subnormals flush to zero.
module fp16_mult #(
    parameter int unsigned LATENCY = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [15:0] dataa,
    input  logic [15:0] datab,
    output logic [15:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        zero,
    output logic        nan
);

    logic              sa, sb, sign;
    logic [4:0]        ea, eb, ea_eff, eb_eff;
    logic [9:0]        ma, mb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [10:0]       siga, sigb;
    logic [21:0]       p, pn;
    logic [4:0]        lz;
    logic signed [7:0] exp_n;
    logic              lsb, guard, sticky, inc;
    logic [14:0]       mag;
    logic [19:0]       stage_in;
`ifdef FP16_MULT_SUBNORMAL_EN
    logic [7:0]        sh;
    logic [63:0]       w;
`endif

    logic [LATENCY*20-1:0] pipe;

    always_comb begin
        sa = dataa[15];
        sb = datab[15];
        ea = dataa[14:10];
        eb = datab[14:10];
        ma = dataa[9:0];
        mb = datab[9:0];
        sign = sa ^ sb;

        a_nan = (ea == 5'd31) && (ma != 10'd0);
        b_nan = (eb == 5'd31) && (mb != 10'd0);
        a_inf = (ea == 5'd31) && (ma == 10'd0);
        b_inf = (eb == 5'd31) && (mb == 10'd0);
`ifdef FP16_MULT_SUBNORMAL_EN
        a_zero = (ea == 5'd0) && (ma == 10'd0);
        b_zero = (eb == 5'd0) && (mb == 10'd0);
        siga   = {ea != 5'd0, ma};
        sigb   = {eb != 5'd0, mb};
`else
        a_zero = (ea == 5'd0);
        b_zero = (eb == 5'd0);
        siga   = {1'b1, ma};
        sigb   = {1'b1, mb};
`endif
        ea_eff = (ea == 5'd0) ? 5'd1 : ea;
        eb_eff = (eb == 5'd0) ? 5'd1 : eb;

        p = {11'd0, siga} * {11'd0, sigb};

        // Left-justify the product so the leading one sits at bit 21.
        lz = '0;
        for (int unsigned i = 0; i < 22; i++) begin
            if (p[i]) lz = 5'(21 - i);
        end
        pn    = p << lz;
        exp_n = 8'(ea_eff) + 8'(eb_eff) - 8'sd14 - 8'(lz);

        lsb    = pn[11];
        guard  = pn[10];
        sticky = |pn[9:0];
        inc    = guard & (sticky | lsb);
        // The implicit one in pn[21] adds back the 1 taken off the exponent; a rounding carry
        // ripples into the exponent field on its own.
        mag    = {exp_n[4:0] - 5'd1, 10'd0} + {4'd0, pn[21:11]} + {14'd0, inc};

`ifdef FP16_MULT_SUBNORMAL_EN
        sh = 8'(8'sd1 - exp_n);
        w  = {pn, 42'd0} >> sh;
        if (exp_n < 8'sd1) begin
            inc = w[52] & ((|w[51:0]) | w[53]);
            mag = {4'd0, w[63:53]} + {14'd0, inc};
        end
`endif

        stage_in = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            stage_in = {16'h7E00, 4'b0001};
        else if (a_inf || b_inf)
            stage_in = {sign, 15'h7C00, 4'b0000};
        else if (a_zero || b_zero)
            stage_in = {sign, 15'd0, 4'b0010};
        else if (exp_n > 8'sd30)
            stage_in = {sign, 15'h7C00, 4'b1000};
`ifndef FP16_MULT_SUBNORMAL_EN
        else if (exp_n < 8'sd1)
            stage_in = {sign, 15'd0, 4'b0110};
`endif
        else if (mag[14:10] == 5'd31)
            stage_in = {sign, 15'h7C00, 4'b1000};
`ifdef FP16_MULT_SUBNORMAL_EN
        else if (mag[14:10] == 5'd0)
            stage_in = {sign, mag, 1'b0, 1'b1, mag == 15'd0, 1'b0};
`endif
        else
            stage_in = {sign, mag, 4'b0000};
    end

    // Each 20-bit slot holds {result, overflow, underflow, zero, nan}; slot 0 is the newest.
    always_ff @(posedge clock) begin
        if (reset)
            pipe <= '0;
        else if (clk_en)
            pipe <= {pipe[(LATENCY-1)*20-1:0], stage_in};
    end

    assign {result, overflow, underflow, zero, nan} = pipe[LATENCY*20-1 -: 20];

endmodule

// File: tb/tb_fp16_mult.sv
// Directed bench for fp16_mult: a delay line of hand-computed expectations is compared every cycle.
module tb_fp16_mult;

    localparam int unsigned LAT = 8;
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_OVF  = 4'b1000;
    localparam logic [3:0] F_UDF  = 4'b0100;
    localparam logic [3:0] F_ZRO  = 4'b0010;
    localparam logic [3:0] F_NAN  = 4'b0001;

    logic        clock = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [15:0] dataa;
    logic [15:0] datab;
    logic [15:0] result;
    logic        overflow;
    logic        underflow;
    logic        zero;
    logic        nan;

    int n_cmp = 0;
    int n_err = 0;

    logic [19:0] model [LAT];
    logic [51:0] vecs [$];

    fp16_mult #(.LATENCY(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .clk_en    (clk_en),
        .dataa     (dataa),
        .datab     (datab),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero),
        .nan       (nan)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got result=%h ovf/udf/zero/nan=%b, expected result=%h ovf/udf/zero/nan=%b",
                     tag, got[19:4], got[3:0], exp[19:4], exp[3:0]);
        end
    endtask

    task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [19:0] e, input logic en, input logic rst);
        dataa  = a;
        datab  = b;
        clk_en = en;
        reset  = rst;
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < LAT; i++) model[i] = '0;
        end else if (en) begin
            for (int i = LAT - 1; i > 0; i--) model[i] = model[i-1];
            model[0] = e;
        end
        #1;
        check(tag, {result, overflow, underflow, zero, nan}, model[LAT-1]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        clk_en = 1'b1;
        dataa  = 16'h3C00;
        datab  = 16'h3C00;

        vecs.push_back({16'h3C00, 16'h4000, 16'h4000, F_NONE});
        vecs.push_back({16'h3C00, 16'h3C00, 16'h3C00, F_NONE});
        vecs.push_back({16'h4000, 16'h4000, 16'h4400, F_NONE});
        vecs.push_back({16'hC000, 16'h3800, 16'hBC00, F_NONE});
        vecs.push_back({16'h7BFF, 16'h4000, 16'h7C00, F_OVF});
        vecs.push_back({16'h7C00, 16'h0000, 16'h7E00, F_NAN});
        vecs.push_back({16'h0400, 16'h0400, 16'h0000, F_UDF | F_ZRO});
        vecs.push_back({16'h8000, 16'h3C00, 16'h8000, F_ZRO});
        vecs.push_back({16'h3C01, 16'h3E00, 16'h3E02, F_NONE});
        vecs.push_back({16'h3C03, 16'h3E00, 16'h3E04, F_NONE});
        vecs.push_back({16'h3DA8, 16'h3DA8, 16'h4000, F_NONE});
        vecs.push_back({16'h3BFF, 16'h3C01, 16'h3C00, F_NONE});
        vecs.push_back({16'hFBFF, 16'h4000, 16'hFC00, F_OVF});
        vecs.push_back({16'h7C00, 16'hC000, 16'hFC00, F_NONE});
        vecs.push_back({16'h7C00, 16'hFC00, 16'hFC00, F_NONE});
        vecs.push_back({16'hFD00, 16'h3C00, 16'h7E00, F_NAN});
        vecs.push_back({16'h8000, 16'h7C00, 16'h7E00, F_NAN});
        vecs.push_back({16'h8000, 16'hC000, 16'h0000, F_ZRO});
`ifdef FP16_MULT_SUBNORMAL_EN
        vecs.push_back({16'h0001, 16'h3C00, 16'h0001, F_UDF});
        vecs.push_back({16'h0400, 16'h3800, 16'h0200, F_UDF});
        vecs.push_back({16'h0001, 16'h3800, 16'h0000, F_UDF | F_ZRO});
        vecs.push_back({16'h0003, 16'h3800, 16'h0002, F_UDF});
`else
        vecs.push_back({16'h0001, 16'h3C00, 16'h0000, F_ZRO});
        vecs.push_back({16'h0400, 16'h3800, 16'h0000, F_UDF | F_ZRO});
        vecs.push_back({16'h0001, 16'h3800, 16'h0000, F_ZRO});
        vecs.push_back({16'h0003, 16'h3800, 16'h0000, F_ZRO});
`endif

        for (int i = 0; i < 3; i++)
            step("reset", 16'h3C00, 16'h3C00, {16'h3C00, F_NONE}, 1'b1, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 6) begin
                for (int k = 0; k < 5; k++)
                    step("hold", 16'h7C00, 16'h0000, {16'h7E00, F_NAN}, 1'b0, 1'b0);
            end
            step($sformatf("vec%0d", i), vecs[i][51:36], vecs[i][35:20], vecs[i][19:0], 1'b1, 1'b0);
        end

        for (int i = 0; i < 9; i++)
            step("drain", 16'h0000, 16'h0000, {16'h0000, F_ZRO}, 1'b1, 1'b0);

        step("inflight", 16'h3C00, 16'h4000, {16'h4000, F_NONE}, 1'b1, 1'b0);
        step("inflight", 16'h4000, 16'h4000, {16'h4400, F_NONE}, 1'b1, 1'b0);
        step("inflight", 16'h3DA8, 16'h3DA8, {16'h4000, F_NONE}, 1'b1, 1'b0);
        step("abort", 16'h3C00, 16'h3C00, {16'h3C00, F_NONE}, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++)
            step("post_abort", 16'h0000, 16'h0000, {16'h0000, F_ZRO}, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
